pa_soc_uart_dbg_master: RTL and testbench
=========================================

// Module: pa_soc_uart_dbg_master
// PURPOSE
//  UART-driven debug bus initiator: second master on the SoC data bus, beside the core's dbus.
//  Receives command frames on a serial pad and issues single-word read/write accesses to any slave (TCM, timer, UARTs).
//  Returns an ack (write) or the read data (read) on the serial tx pad; used for image load and peek/poke during bring-up.
//  Bus ownership is requested and granted per access via req/gnt; the SoC arbiter muxes this master against the core.
// PARAMETERS
//  CLK_DIV   434      clk_i cycles per UART bit (50 MHz / 115200)
//  TIMEOUT   2000000  max idle cycles between bytes of one frame before the frame is discarded
// PORTS
//  clk_i      in   1   system clock
//  rst_n_i    in   1   asynchronous active-low reset
//  pad_rxd    in   1   serial command input, asynchronous, idle high
//  pad_txd    out  1   serial response output, idle high
//  bus_req_o  out  1   bus request to the arbiter
//  bus_gnt_i  in   1   bus grant from the arbiter
//  addr_o     out  32  bus address
//  rd_o       out  1   read strobe, one cycle
//  we_o       out  1   write strobe, one cycle
//  size_o     out  3   access size; constant 3'b010 (word)
//  data_o     out  32  write data
//  data_i     in   32  read data from the slave mux
//  busy_o     out  1   high from the first byte of a frame until its response is fully sent
// BEHAVIOUR
//  Reset: pad_txd=1; bus_req_o, rd_o, we_o, busy_o = 0; addr_o and data_o = 0; size_o = 3'b010; FSM in IDLE.
//  Reset is honoured mid-frame and mid-TX. pad_txd returns high asynchronously with reset.
//  RX:
//   - pad_rxd passes through a 2-flop synchroniser before any use.
//   - A falling edge starts a byte; the start bit is re-checked at CLK_DIV/2 and the byte is aborted if the line is high.
//   - 8 data bits are sampled LSB first, each at its bit centre.
//   - The stop bit must be 1; otherwise the byte is dropped silently and the frame byte count does not advance.
//  TX: 8N1, LSB first, CLK_DIV cycles per bit, with back-to-back response bytes and no idle gap.
//  Frames (multi-byte fields are MSB first):
//   - 0x57 'W' + A3 A2 A1 A0 + D3 D2 D1 D0 -> write word; response 0x4B.
//   - 0x52 'R' + A3 A2 A1 A0 -> read word; response D3 D2 D1 D0.
//   - Any other command byte -> response 0x45, no bus activity, then IDLE.
//  FSM:
//   - IDLE -> CMD on the first valid byte.
//   - CMD/ADDR/WDATA collect bytes, then -> REQ.
//   - REQ -> ACC once bus_gnt_i=1.
//   - ACC -> RDWAIT (read) or RESP (write).
//   - RDWAIT -> RESP.
//   - RESP -> IDLE after the last response byte's stop bit.
//  Bus handshake:
//   - bus_req_o rises on entry to REQ and holds until the end of ACC (write) or RDWAIT (read).
//   - rd_o/we_o pulse for exactly one cycle, in the first cycle with bus_gnt_i=1 while req is high.
//   - addr_o and data_o are stable from REQ entry until req falls.
//   - Read data is captured from data_i on the cycle after the rd_o pulse (synchronous-read slaves).
//   - A grant withdrawn before the strobe stalls the access; exactly one strobe is issued per frame.
//   - bus_gnt_i is ignored outside REQ.
//  Timeout: an inter-byte gap > TIMEOUT cycles while in CMD/ADDR/WDATA discards the frame; -> IDLE, no response, no bus activity.
//  RX bytes arriving during REQ/ACC/RDWAIT/RESP are discarded; there is no queueing.
//  Counters: the bit-timing counter is clog2(CLK_DIV) bits wide; the timeout counter saturates and does not wrap.
//  Byte index counters wrap cleanly at the frame length.
// TESTING
//  1. rx 57 10 00 00 04 DE AD BE EF, gnt=1 -> one-cycle we_o, addr_o=0x10000004, data_o=0xDEADBEEF, size_o=010; then tx 0x4B.
//  2. rx 52 10 00 00 04, slave returns 0x12345678 the cycle after rd_o -> tx 12 34 56 78; busy_o falls after the last stop bit.
//  3. Read frame with gnt=0 for 100 cycles -> req held, no strobe; gnt=1 -> exactly one rd_o pulse, req drops after capture.
//  4. rx 0x33 -> tx 0x45, no bus activity; a following valid write frame completes normally.
//  5. rx 57 10 00, then silence > TIMEOUT -> IDLE, no response, no strobe; the next frame works.
//  6. Byte with stop bit 0 -> dropped, frame count unchanged; reset asserted mid-response -> pad_txd=1 and busy_o=0 immediately.

Source files
------------

// File: rtl/pa_soc_uart_dbg_master.sv
// UART debug bus initiator: receives 8N1 command frames, performs one
// word read or write on the SoC data bus through a req/gnt handshake and
// returns an ack byte or the read word on the serial transmit pad.
module pa_soc_uart_dbg_master #(
    parameter int CLK_DIV = 434,
    parameter int TIMEOUT = 2000000
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        pad_rxd,
    output logic        pad_txd,
    output logic        bus_req_o,
    input  logic        bus_gnt_i,
    output logic [31:0] addr_o,
    output logic        rd_o,
    output logic        we_o,
    output logic [2:0]  size_o,
    output logic [31:0] data_o,
    input  logic [31:0] data_i,
    output logic        busy_o
);

    localparam int CW  = $clog2(CLK_DIV);
    localparam int TOW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  DIV_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0]  DIV_HALF = CW'(CLK_DIV / 2);
    localparam logic [TOW-1:0] TO_MAX   = TOW'(TIMEOUT);

    localparam logic [7:0] CMD_WR  = 8'h57;
    localparam logic [7:0] CMD_RD  = 8'h52;
    localparam logic [7:0] RSP_ACK = 8'h4B;
    localparam logic [7:0] RSP_ERR = 8'h45;

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CMD    = 3'd1;
    localparam logic [2:0] S_ADDR   = 3'd2;
    localparam logic [2:0] S_WDATA  = 3'd3;
    localparam logic [2:0] S_REQ    = 3'd4;
    localparam logic [2:0] S_ACC    = 3'd5;
    localparam logic [2:0] S_RDWAIT = 3'd6;
    localparam logic [2:0] S_RESP   = 3'd7;

    // ---------------- receiver ----------------
    logic          r_rxd_s1, r_rxd_s2, r_rxd_d;
    logic [1:0]    r_rx_st;
    logic [CW-1:0] r_rx_cnt;
    logic [2:0]    r_rx_bit;
    logic [7:0]    r_rx_sh;
    logic          r_rx_vld;

    // two-flop synchroniser plus a delayed copy for falling-edge detection
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_rxd_s1 <= 1'b1;
            r_rxd_s2 <= 1'b1;
            r_rxd_d  <= 1'b1;
        end else begin
            r_rxd_s1 <= pad_rxd;
            r_rxd_s2 <= r_rxd_s1;
            r_rxd_d  <= r_rxd_s2;
        end
    end

    // byte receiver: start re-check at half bit, then sample at bit centres;
    // a byte only becomes valid when its stop bit reads high
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_rx_st  <= RX_IDLE;
            r_rx_cnt <= '0;
            r_rx_bit <= '0;
            r_rx_sh  <= '0;
            r_rx_vld <= 1'b0;
        end else begin
            r_rx_vld <= 1'b0;
            case (r_rx_st)
                RX_IDLE: begin
                    if (r_rxd_d && !r_rxd_s2) begin
                        r_rx_st  <= RX_START;
                        r_rx_cnt <= '0;
                    end
                end
                RX_START: begin
                    if (r_rx_cnt == DIV_HALF) begin
                        r_rx_cnt <= '0;
                        r_rx_bit <= '0;
                        r_rx_st  <= r_rxd_s2 ? RX_IDLE : RX_DATA;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (r_rx_cnt == DIV_LAST) begin
                        r_rx_cnt <= '0;
                        r_rx_sh  <= {r_rxd_s2, r_rx_sh[7:1]};
                        r_rx_bit <= r_rx_bit + 1'b1;
                        if (r_rx_bit == 3'd7) r_rx_st <= RX_STOP;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                default: begin
                    if (r_rx_cnt == DIV_LAST) begin
                        r_rx_cnt <= '0;
                        r_rx_st  <= RX_IDLE;
                        r_rx_vld <= r_rxd_s2;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    // ---------------- transmitter ----------------
    logic          r_tx_act;
    logic [8:0]    r_tx_sh;
    logic [3:0]    r_tx_bit;
    logic [CW-1:0] r_tx_cnt;
    logic          r_txd;
    logic          w_tx_end, w_tx_rdy, w_tx_load;
    logic [7:0]    w_tx_data;

    // the next byte may be loaded in the last cycle of a stop bit so that
    // response bytes follow each other with no idle gap
    assign w_tx_end = r_tx_act && (r_tx_cnt == DIV_LAST) && (r_tx_bit == 4'd9);
    assign w_tx_rdy = !r_tx_act || w_tx_end;

    // shift out start, 8 data bits LSB first, stop; line held high when idle
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_tx_act <= 1'b0;
            r_tx_sh  <= '1;
            r_tx_bit <= '0;
            r_tx_cnt <= '0;
            r_txd    <= 1'b1;
        end else if (w_tx_load) begin
            r_tx_act <= 1'b1;
            r_tx_sh  <= {1'b1, w_tx_data};
            r_tx_bit <= '0;
            r_tx_cnt <= '0;
            r_txd    <= 1'b0;
        end else if (r_tx_act) begin
            if (r_tx_cnt == DIV_LAST) begin
                r_tx_cnt <= '0;
                if (r_tx_bit == 4'd9) begin
                    r_tx_act <= 1'b0;
                end else begin
                    r_tx_bit <= r_tx_bit + 1'b1;
                    r_txd    <= r_tx_sh[0];
                    r_tx_sh  <= {1'b1, r_tx_sh[8:1]};
                end
            end else begin
                r_tx_cnt <= r_tx_cnt + 1'b1;
            end
        end
    end

    assign pad_txd = r_txd;

    // ---------------- frame / bus FSM ----------------
    logic [2:0]     r_st;
    logic           r_is_wr, r_err;
    logic [1:0]     r_idx;
    logic [31:0]    r_addr, r_wdata, r_rdata;
    logic           r_bus_req;
    logic [2:0]     r_resp_idx;
    logic [TOW-1:0] r_to_cnt;
    logic           w_collect, w_timeout, w_strobe;
    logic [2:0]     w_resp_len;

    assign w_collect  = (r_st == S_CMD) || (r_st == S_ADDR) || (r_st == S_WDATA);
    assign w_timeout  = (r_to_cnt == TO_MAX);
    assign w_strobe   = (r_st == S_REQ) && bus_gnt_i;
    assign w_resp_len = (r_err || r_is_wr) ? 3'd1 : 3'd4;
    assign w_tx_load  = (r_st == S_RESP) && (r_resp_idx != w_resp_len) && w_tx_rdy;

    // response byte: error code, write ack, or read word MSB first
    always_comb begin
        w_tx_data = RSP_ERR;
        if (!r_err) begin
            if (r_is_wr) begin
                w_tx_data = RSP_ACK;
            end else begin
                case (r_resp_idx[1:0])
                    2'd0:    w_tx_data = r_rdata[31:24];
                    2'd1:    w_tx_data = r_rdata[23:16];
                    2'd2:    w_tx_data = r_rdata[15:8];
                    default: w_tx_data = r_rdata[7:0];
                endcase
            end
        end
    end

    // inter-byte idle counter; runs only while a frame is being collected
    // and the receiver is idle, saturating at the limit
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_to_cnt <= '0;
        end else if (!w_collect || (r_rx_st != RX_IDLE) || r_rx_vld) begin
            r_to_cnt <= '0;
        end else if (!w_timeout) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    // frame sequencing and bus handshake; address and write data only
    // change while bytes are being collected, so they are stable under req
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_st       <= S_IDLE;
            r_is_wr    <= 1'b0;
            r_err      <= 1'b0;
            r_idx      <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_bus_req  <= 1'b0;
            r_resp_idx <= '0;
        end else begin
            case (r_st)
                S_IDLE: begin
                    if (r_rx_vld) begin
                        r_is_wr <= (r_rx_sh == CMD_WR);
                        r_err   <= (r_rx_sh != CMD_WR) && (r_rx_sh != CMD_RD);
                        r_idx   <= '0;
                        r_st    <= S_CMD;
                    end
                end
                S_CMD: begin
                    r_resp_idx <= '0;
                    r_st       <= r_err ? S_RESP : S_ADDR;
                end
                S_ADDR: begin
                    if (w_timeout) begin
                        r_st <= S_IDLE;
                    end else if (r_rx_vld) begin
                        r_addr <= {r_addr[23:0], r_rx_sh};
                        r_idx  <= r_idx + 1'b1;
                        if (r_idx == 2'd3) begin
                            if (r_is_wr) begin
                                r_st <= S_WDATA;
                            end else begin
                                r_st      <= S_REQ;
                                r_bus_req <= 1'b1;
                            end
                        end
                    end
                end
                S_WDATA: begin
                    if (w_timeout) begin
                        r_st <= S_IDLE;
                    end else if (r_rx_vld) begin
                        r_wdata <= {r_wdata[23:0], r_rx_sh};
                        r_idx   <= r_idx + 1'b1;
                        if (r_idx == 2'd3) begin
                            r_st      <= S_REQ;
                            r_bus_req <= 1'b1;
                        end
                    end
                end
                S_REQ: begin
                    if (bus_gnt_i) r_st <= S_ACC;
                end
                S_ACC: begin
                    if (r_is_wr) begin
                        r_st      <= S_RESP;
                        r_bus_req <= 1'b0;
                    end else begin
                        // synchronous-read slave: data valid the cycle after rd_o
                        r_rdata <= data_i;
                        r_st    <= S_RDWAIT;
                    end
                end
                S_RDWAIT: begin
                    r_st      <= S_RESP;
                    r_bus_req <= 1'b0;
                end
                default: begin
                    if (w_tx_load) r_resp_idx <= r_resp_idx + 1'b1;
                    if ((r_resp_idx == w_resp_len) && w_tx_end) r_st <= S_IDLE;
                end
            endcase
        end
    end

    assign bus_req_o = r_bus_req;
    assign rd_o      = w_strobe && !r_is_wr;
    assign we_o      = w_strobe && r_is_wr;
    assign addr_o    = r_addr;
    assign data_o    = r_wdata;
    assign size_o    = 3'b010;
    assign busy_o    = (r_st != S_IDLE);

endmodule

// File: tb/tb_pa_soc_uart_dbg_master.sv
// Randomised frame-level bench for the UART debug bus master: a UART
// driver, a UART decoder on pad_txd, a synchronous-read slave and a
// word-memory reference model that predicts responses and bus accesses.
module tb_pa_soc_uart_dbg_master;

    localparam int DIV = 16;
    localparam int TO  = 400;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pad_rxd = 1'b1;
    logic        pad_txd;
    logic        bus_req, bus_gnt = 1'b0;
    logic [31:0] addr_o, data_o, data_i;
    logic        rd_o, we_o, busy;
    logic [2:0]  size_o;

    pa_soc_uart_dbg_master #(.CLK_DIV(DIV), .TIMEOUT(TO)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .pad_rxd(pad_rxd), .pad_txd(pad_txd),
        .bus_req_o(bus_req), .bus_gnt_i(bus_gnt), .addr_o(addr_o), .rd_o(rd_o),
        .we_o(we_o), .size_o(size_o), .data_o(data_o), .data_i(data_i), .busy_o(busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    // reference model (stimulus-driven) and slave storage (DUT-driven)
    logic [31:0] ref_mem[logic [31:0]];
    logic [31:0] slv_mem[logic [31:0]];

    // bus monitor
    int          n_strobe = 0, n_unstable = 0, req_after = 0;
    bit          counting = 0;
    logic [31:0] s_addr, s_data, p_addr, p_data;
    logic        s_we, s_req, p_req = 1'b0;
    logic [2:0]  s_size;

    always @(negedge clk) begin
        if (rst_n) begin
            if (we_o || rd_o) begin
                n_strobe++;
                s_addr = addr_o; s_data = data_o; s_we = we_o;
                s_req = bus_req; s_size = size_o;
                req_after = 0; counting = 1;
                if (we_o) slv_mem[addr_o] = data_o;
            end else if (counting) begin
                if (bus_req) req_after++;
                else counting = 0;
            end
            if (bus_req && p_req && (addr_o !== p_addr || data_o !== p_data)) n_unstable++;
            p_req = bus_req; p_addr = addr_o; p_data = data_o;
        end
    end

    // synchronous-read slave: data valid only in the cycle after rd_o
    initial begin
        logic [31:0] v;
        data_i = $urandom;
        forever begin
            @(negedge clk);
            if (rd_o) begin
                v = slv_mem.exists(addr_o) ? slv_mem[addr_o] : dflt(addr_o);
                @(posedge clk); #1 data_i = v;
                @(posedge clk); #1 data_i = $urandom;
            end
        end
    end

    // UART decoder on pad_txd
    logic [7:0] tx_q[$];
    int         n_txferr = 0;
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge pad_txd);
            repeat (DIV / 2) @(negedge clk);
            if (pad_txd == 1'b0) begin
                for (int i = 0; i < 8; i++) begin
                    repeat (DIV) @(negedge clk);
                    b[i] = pad_txd;
                end
                repeat (DIV) @(negedge clk);
                if (pad_txd !== 1'b1) n_txferr++;
                tx_q.push_back(b);
            end
        end
    end

    initial begin
        #(10 * 95000);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic send_byte(input logic [7:0] b, input logic stop);
        pad_rxd = 1'b0; tick(DIV);
        for (int i = 0; i < 8; i++) begin
            pad_rxd = b[i]; tick(DIV);
        end
        pad_rxd = stop; tick(DIV);
        pad_rxd = 1'b1; tick(2);
    endtask

    task automatic wait_tx(input int n, input int budget);
        int k = 0;
        while (tx_q.size() < n && k < budget) begin
            @(negedge clk); k++;
        end
        if (tx_q.size() < n) chk("tx_wait", tx_q.size(), n);
    endtask

    // one frame: cmd, optional address/data, grant after gdly cycles
    // (0 = grant held high throughout), optional bad-stop byte before bad_pos
    task automatic do_frame(input logic [7:0] cmd, input logic [31:0] a,
                            input logic [31:0] d, input int gdly, input int bad_pos);
        logic [7:0]  bytes[$];
        logic [7:0]  exp[$];
        logic [31:0] rv;
        bit          is_w, is_r;
        int          s0, k;
        is_w = (cmd == 8'h57);
        is_r = (cmd == 8'h52);
        bytes.push_back(cmd);
        if (is_w || is_r)
            for (int i = 3; i >= 0; i--) bytes.push_back(a[8*i +: 8]);
        if (is_w) begin
            for (int i = 3; i >= 0; i--) bytes.push_back(d[8*i +: 8]);
            exp.push_back(8'h4B);
            ref_mem[a] = d;
        end else if (is_r) begin
            rv = ref_mem.exists(a) ? ref_mem[a] : dflt(a);
            for (int i = 3; i >= 0; i--) exp.push_back(rv[8*i +: 8]);
        end else begin
            exp.push_back(8'h45);
        end
        tx_q.delete();
        s0 = n_strobe; n_unstable = 0;
        bus_gnt = (gdly == 0);
        foreach (bytes[i]) begin
            if (i == bad_pos) send_byte(8'($urandom), 1'b0);
            send_byte(bytes[i], 1'b1);
        end
        if ((is_w || is_r) && gdly > 0) begin
            k = 0;
            while (!bus_req && k < 4 * DIV) begin tick(1); k++; end
            chk("req_up", bus_req, 1'b1);
            tick(gdly);
            chk("stall_nostrobe", n_strobe - s0, 0);
            chk("stall_req_held", bus_req, 1'b1);
            bus_gnt = 1'b1;
        end
        wait_tx(exp.size(), exp.size() * 12 * DIV + 400);
        chk("busy_at_last_stop", busy, 1'b1);
        repeat (DIV) @(negedge clk);
        chk("busy_after_resp", busy, 1'b0);
        tick(1);
        bus_gnt = 1'b0;
        chk("tx_count", tx_q.size(), exp.size());
        foreach (exp[i]) if (i < tx_q.size()) chk("tx_byte", tx_q[i], exp[i]);
        chk("strobe_count", n_strobe - s0, (is_w || is_r) ? 1 : 0);
        if (is_w || is_r) begin
            chk("addr", s_addr, a);
            chk("we_vs_rd", s_we, is_w);
            if (is_w) chk("wdata", s_data, d);
            chk("size", s_size, 3'b010);
            chk("req_at_strobe", s_req, 1'b1);
            chk("req_after_strobe", req_after, is_w ? 1 : 2);
            chk("addr_data_stable", n_unstable, 0);
        end
        chk("tx_framing", n_txferr, 0);
    endtask

    initial begin
        logic [31:0] a, d;
        logic [7:0]  c;
        int          kind, s0, k;

        // reset state
        tick(3);
        chk("rst_txd", pad_txd, 1'b1);
        chk("rst_req", bus_req, 1'b0);
        chk("rst_rd", rd_o, 1'b0);
        chk("rst_we", we_o, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_addr", addr_o, 32'h0);
        chk("rst_data", data_o, 32'h0);
        chk("rst_size", size_o, 3'b010);
        rst_n = 1'b1;
        tick(5);

        // directed: read with slave word, write, read-back
        slv_mem[32'h1000_0004] = 32'h1234_5678;
        ref_mem[32'h1000_0004] = 32'h1234_5678;
        do_frame(8'h52, 32'h1000_0004, 32'h0, 0, -1);
        do_frame(8'h57, 32'h1000_0004, 32'hDEAD_BEEF, 0, -1);
        do_frame(8'h52, 32'h1000_0004, 32'h0, 100, -1);

        // unknown command, then a normal write
        do_frame(8'h33, 32'h0, 32'h0, 0, -1);
        do_frame(8'h57, 32'h2000_0010, 32'hCAFE_F00D, 5, -1);

        // inter-byte timeout discards the frame
        tx_q.delete();
        s0 = n_strobe;
        send_byte(8'h57, 1'b1); send_byte(8'h10, 1'b1); send_byte(8'h00, 1'b1);
        chk("to_busy_mid", busy, 1'b1);
        tick(TO + 3 * DIV);
        chk("to_idle", busy, 1'b0);
        chk("to_nostrobe", n_strobe - s0, 0);
        chk("to_noresp", tx_q.size(), 0);
        do_frame(8'h52, 32'h2000_0010, 32'h0, 3, -1);

        // byte with bad stop bit is dropped and does not count
        do_frame(8'h57, 32'h3000_0008, 32'h0BAD_57A7, 0, 3);

        // randomised frames
        for (int it = 0; it < 10; it++) begin
            kind = $urandom_range(0, 9);
            a = ($urandom_range(0, 1) != 0) ? (32'h1000_0000 + 32'($urandom_range(0, 3)) * 4)
                                            : $urandom;
            d = $urandom;
            if (kind < 5)      c = 8'h57;
            else if (kind < 9) c = 8'h52;
            else begin
                c = 8'($urandom);
                if (c == 8'h57 || c == 8'h52) c = 8'hFF;
            end
            do_frame(c, a, d, ($urandom_range(0, 1) != 0) ? 0 : $urandom_range(1, 30), -1);
        end

        // reset asserted in the middle of a read response
        tx_q.delete();
        bus_gnt = 1'b1;
        send_byte(8'h52, 1'b1);
        for (int i = 0; i < 4; i++) send_byte(8'h00, 1'b1);
        k = 0;
        while (tx_q.size() < 1 && k < 20 * DIV) begin tick(1); k++; end
        chk("rst_mid_started", tx_q.size(), 1);
        tick(3 * DIV + 3);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_txd", pad_txd, 1'b1);
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_req", bus_req, 1'b0);
        tick(3);
        bus_gnt = 1'b0;
        rst_n = 1'b1;
        tick(12 * DIV);
        tx_q.delete();
        n_txferr = 0;
        do_frame(8'h57, 32'h1000_000C, 32'hA5A5_0F0F, 7, -1);
        do_frame(8'h52, 32'h1000_000C, 32'h0, 0, -1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
